// File: rtl/masked_seq_pkg.sv
// Shared types and default sizing for the masked_arith sequencer.
package masked_seq_pkg;

   localparam int RADIX_DEF   = 13;
   localparam int TIMEOUT_DEF = 4096;
   localparam int TW_DEF      = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REMASK,
      S_LAUNCH,
      S_WAIT,
      S_RESULT
   } seq_state_t;

endpackage

// File: rtl/masked_seq_remask.sv
// Additive share re-masking mod 2^RADIX; MASKED_SEQ_REMASK_EN selects remask vs. pass-through.
module masked_seq_remask
   import masked_seq_pkg::*;
#(
   parameter int RADIX = RADIX_DEF
) (
   input  logic [RADIX-1:0]   p1,
   input  logic [RADIX-1:0]   p2,
   input  logic [RADIX-1:0]   h1,
   input  logic [RADIX-1:0]   h2,
   input  logic [2*RADIX-1:0] rnd,
   output logic [RADIX-1:0]   q_p1,
   output logic [RADIX-1:0]   q_p2,
   output logic [RADIX-1:0]   q_h1,
   output logic [RADIX-1:0]   q_h2
);

`ifdef MASKED_SEQ_REMASK_EN
   logic [RADIX-1:0] r_p;
   logic [RADIX-1:0] r_h;

   assign r_p = rnd[RADIX-1:0];
   assign r_h = rnd[2*RADIX-1:RADIX];

   // Same mask added to one share and subtracted from the other keeps the sum invariant.
   assign q_p1 = p1 + r_p;
   assign q_p2 = p2 - r_p;
   assign q_h1 = h1 + r_h;
   assign q_h2 = h2 - r_h;
`else
   logic unused_rnd;

   assign unused_rnd = ^rnd;
   assign q_p1 = p1;
   assign q_p2 = p2;
   assign q_h1 = h1;
   assign q_h2 = h2;
`endif

endmodule

// File: rtl/masked_arith_seq.sv
// Command sequencer around the masked_arith datapath: remask, launch, timed wait, result handshake.
// Build option MASKED_SEQ_REMASK_EN enables PRNG re-masking of the arithmetic shares.
module masked_arith_seq
   import masked_seq_pkg::*;
#(
   parameter int RADIX   = RADIX_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = TW_DEF
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [RADIX-1:0]   cmd_p1,
   input  logic [RADIX-1:0]   cmd_p2,
   input  logic [RADIX-1:0]   cmd_h1,
   input  logic [RADIX-1:0]   cmd_h2,
   input  logic [RADIX-1:0]   cmd_r,
   input  logic [RADIX-1:0]   cmd_kinv,
   input  logic [2*RADIX-1:0] rnd,
   output logic               rnd_req,
   output logic [RADIX-1:0]   ma_p1,
   output logic [RADIX-1:0]   ma_p2,
   output logic [RADIX-1:0]   ma_h1,
   output logic [RADIX-1:0]   ma_h2,
   output logic [RADIX-1:0]   ma_r,
   output logic [RADIX-1:0]   ma_kinv,
   output logic               ma_start,
   input  logic               ma_done,
   input  logic [RADIX-1:0]   ma_s1,
   input  logic [RADIX-1:0]   ma_s2,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [RADIX-1:0]   res_s1,
   output logic [RADIX-1:0]   res_s2,
   output logic               res_err,
   output logic               busy,
   output logic               trig
);

   seq_state_t state, state_nxt;

   logic [RADIX-1:0] lat_p1, lat_p2, lat_h1, lat_h2, lat_r, lat_kinv;
   logic [RADIX-1:0] rm_p1, rm_p2, rm_h1, rm_h2;
   logic [TW-1:0]    tmo_cnt;
   logic             tmo_hit;

   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

   masked_seq_remask #(.RADIX(RADIX)) u_remask (
      .p1   (lat_p1),
      .p2   (lat_p2),
      .h1   (lat_h1),
      .h2   (lat_h2),
      .rnd  (rnd),
      .q_p1 (rm_p1),
      .q_p2 (rm_p2),
      .q_h1 (rm_h1),
      .q_h2 (rm_h2)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rnd_req   = 1'b0;
      ma_start  = 1'b0;
      res_valid = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = S_REMASK;
         end
         S_REMASK: begin
`ifdef MASKED_SEQ_REMASK_EN
            rnd_req = 1'b1;
`endif
            state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            ma_start  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // done is checked first so a late done on the last cycle still succeeds
            if (ma_done || tmo_hit) state_nxt = S_RESULT;
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         lat_p1   <= '0;
         lat_p2   <= '0;
         lat_h1   <= '0;
         lat_h2   <= '0;
         lat_r    <= '0;
         lat_kinv <= '0;
      end else if (state == S_IDLE && cmd_valid) begin
         lat_p1   <= cmd_p1;
         lat_p2   <= cmd_p2;
         lat_h1   <= cmd_h1;
         lat_h2   <= cmd_h2;
         lat_r    <= cmd_r;
         lat_kinv <= cmd_kinv;
      end
   end

   // Datapath operands change only here, so they stay put for the whole execution window.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ma_p1   <= '0;
         ma_p2   <= '0;
         ma_h1   <= '0;
         ma_h2   <= '0;
         ma_r    <= '0;
         ma_kinv <= '0;
      end else if (state == S_REMASK) begin
         ma_p1   <= rm_p1;
         ma_p2   <= rm_p2;
         ma_h1   <= rm_h1;
         ma_h2   <= rm_h2;
         ma_r    <= lat_r;
         ma_kinv <= lat_kinv;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == S_LAUNCH) begin
         tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         res_s1  <= '0;
         res_s2  <= '0;
         res_err <= 1'b0;
      end else if (state == S_WAIT) begin
         if (ma_done) begin
            res_s1  <= ma_s1;
            res_s2  <= ma_s2;
            res_err <= 1'b0;
         end else if (tmo_hit) begin
            res_s1  <= '0;
            res_s2  <= '0;
            res_err <= 1'b1;
         end
      end
   end

   // Registered so the scope sees a clean edge aligned with ma_start and the RESULT entry.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) trig <= 1'b0;
      else        trig <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);
   end

endmodule

// File: tb/tb_masked_arith_seq.sv
// Directed self-checking bench for masked_arith_seq (expects depend on MASKED_SEQ_REMASK_EN).
module tb_masked_arith_seq;

   localparam int RADIX   = 13;
   localparam int TIMEOUT = 4096;
   localparam int TW      = 16;
`ifdef MASKED_SEQ_REMASK_EN
   localparam bit REMASK_ON = 1'b1;
`else
   localparam bit REMASK_ON = 1'b0;
`endif

   logic               clock = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [RADIX-1:0]   cmd_p1 = '0, cmd_p2 = '0, cmd_h1 = '0, cmd_h2 = '0, cmd_r = '0, cmd_kinv = '0;
   logic [2*RADIX-1:0] rnd = '0;
   logic               rnd_req;
   logic [RADIX-1:0]   ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv;
   logic               ma_start;
   logic               ma_done = 1'b0;
   logic [RADIX-1:0]   ma_s1 = '0, ma_s2 = '0;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic [RADIX-1:0]   res_s1, res_s2;
   logic               res_err, busy, trig;

   int n_tests = 0;
   int n_fail  = 0;

   masked_arith_seq #(.RADIX(RADIX), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clock(clock), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_p1(cmd_p1), .cmd_p2(cmd_p2), .cmd_h1(cmd_h1), .cmd_h2(cmd_h2),
      .cmd_r(cmd_r), .cmd_kinv(cmd_kinv),
      .rnd(rnd), .rnd_req(rnd_req),
      .ma_p1(ma_p1), .ma_p2(ma_p2), .ma_h1(ma_h1), .ma_h2(ma_h2),
      .ma_r(ma_r), .ma_kinv(ma_kinv),
      .ma_start(ma_start), .ma_done(ma_done), .ma_s1(ma_s1), .ma_s2(ma_s2),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_s1(res_s1), .res_s2(res_s2), .res_err(res_err),
      .busy(busy), .trig(trig)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Presents one command for a single cycle; returns in the REMASK cycle.
   task automatic issue_cmd(input logic [RADIX-1:0] p1, p2, h1, h2, r, kinv,
                            input logic [2*RADIX-1:0] w);
      cmd_p1 = p1; cmd_p2 = p2; cmd_h1 = h1; cmd_h2 = h2; cmd_r = r; cmd_kinv = kinv;
      rnd = w;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // From a WAIT cycle: pulse done and complete the result handshake.
   task automatic finish_run(input logic [RADIX-1:0] s1, s2);
      ma_done = 1'b1; ma_s1 = s1; ma_s2 = s2;
      tick();
      ma_done = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick();
      n_tests++; if ({cmd_ready, rnd_req, ma_start, res_valid, res_err, busy, trig} !== 7'b1000000) begin
         n_fail++; $display("FAIL reset_ctl got=%b exp=1000000", {cmd_ready, rnd_req, ma_start, res_valid, res_err, busy, trig}); end
      n_tests++; if ({ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv, res_s1, res_s2} !== '0) begin
         n_fail++; $display("FAIL reset_data got=%h exp=0", {ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv, res_s1, res_s2}); end
      @(negedge clock);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_nominal;
      automatic logic [4*RADIX-1:0] exp_ops = REMASK_ON ? {13'h0133, 13'h0446, 13'h0A20, 13'h1FF1}
                                                        : {13'h0123, 13'h0456, 13'h0A00, 13'h0011};
      n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL nom_idle_ready got=%b exp=1", cmd_ready); end
      issue_cmd(13'h0123, 13'h0456, 13'h0A00, 13'h0011, 13'h0777, 13'h1357, {13'h0020, 13'h0010});
      n_tests++; if (rnd_req !== REMASK_ON) begin n_fail++; $display("FAIL nom_rnd_req got=%b exp=%b", rnd_req, REMASK_ON); end
      n_tests++; if ({ma_start, cmd_ready, busy} !== 3'b001) begin
         n_fail++; $display("FAIL nom_remask_ctl got=%b exp=001", {ma_start, cmd_ready, busy}); end
      tick();
      n_tests++; if ({ma_start, trig, rnd_req} !== 3'b110) begin
         n_fail++; $display("FAIL nom_launch got=%b exp=110", {ma_start, trig, rnd_req}); end
      n_tests++; if ({ma_p1, ma_p2, ma_h1, ma_h2} !== exp_ops) begin
         n_fail++; $display("FAIL nom_operands got=%h exp=%h", {ma_p1, ma_p2, ma_h1, ma_h2}, exp_ops); end
      n_tests++; if ({ma_r, ma_kinv} !== {13'h0777, 13'h1357}) begin
         n_fail++; $display("FAIL nom_r_kinv got=%h exp=%h", {ma_r, ma_kinv}, {13'h0777, 13'h1357}); end
      // done during LAUNCH must be ignored
      ma_done = 1'b1; ma_s1 = 13'h1FFF; ma_s2 = 13'h1FFF;
      tick();
      ma_done = 1'b0;
      n_tests++; if ({res_valid, trig, ma_start, busy} !== 4'b0101) begin
         n_fail++; $display("FAIL nom_launch_done_ignored got=%b exp=0101", {res_valid, trig, ma_start, busy}); end
      repeat (39) tick();
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL nom_pre_done got=%b exp=0", res_valid); end
      ma_done = 1'b1; ma_s1 = 13'h0ABC; ma_s2 = 13'h1234;
      tick();
      ma_done = 1'b0;
      n_tests++; if ({res_valid, res_err, trig, cmd_ready, busy} !== 5'b10001) begin
         n_fail++; $display("FAIL nom_result_ctl got=%b exp=10001", {res_valid, res_err, trig, cmd_ready, busy}); end
      n_tests++; if ({res_s1, res_s2} !== {13'h0ABC, 13'h1234}) begin
         n_fail++; $display("FAIL nom_result_data got=%h exp=%h", {res_s1, res_s2}, {13'h0ABC, 13'h1234}); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_tests++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin
         n_fail++; $display("FAIL nom_back_idle got=%b exp=010", {res_valid, cmd_ready, busy}); end
   endtask

   task automatic test_wrap;
      automatic logic [2*RADIX-1:0] exp_p = REMASK_ON ? {13'h0001, 13'h1FFF} : {13'h1FFF, 13'h0001};
      automatic logic [RADIX-1:0] sum;
      issue_cmd(13'h1FFF, 13'h0001, 13'h0100, 13'h0200, 13'h0, 13'h0, {13'h0000, 13'h0002});
      tick();
      sum = ma_p1 + ma_p2;
      n_tests++; if ({ma_p1, ma_p2} !== exp_p) begin
         n_fail++; $display("FAIL wrap_operands got=%h exp=%h", {ma_p1, ma_p2}, exp_p); end
      n_tests++; if (sum !== 13'h0000) begin n_fail++; $display("FAIL wrap_sum got=%h exp=0000", sum); end
      n_tests++; if ({ma_h1, ma_h2} !== {13'h0100, 13'h0200}) begin
         n_fail++; $display("FAIL wrap_h_zero_mask got=%h exp=%h", {ma_h1, ma_h2}, {13'h0100, 13'h0200}); end
      tick();
      finish_run(13'h0042, 13'h0043);
   endtask

   task automatic test_timeout;
      // abort path: no done at all
      issue_cmd(13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005, 13'h0006, '0);
      tick();
      tick();
      repeat (TIMEOUT - 1) tick();
      n_tests++; if ({res_valid, trig, busy} !== 3'b011) begin
         n_fail++; $display("FAIL tmo_last_wait got=%b exp=011", {res_valid, trig, busy}); end
      tick();
      n_tests++; if ({res_valid, res_err, trig} !== 3'b110) begin
         n_fail++; $display("FAIL tmo_abort_ctl got=%b exp=110", {res_valid, res_err, trig}); end
      n_tests++; if ({res_s1, res_s2} !== '0) begin
         n_fail++; $display("FAIL tmo_abort_data got=%h exp=0", {res_s1, res_s2}); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      // done on the final WAIT cycle wins over the timeout
      issue_cmd(13'h0001, 13'h0002, 13'h0003, 13'h0004, 13'h0005, 13'h0006, '0);
      tick();
      tick();
      repeat (TIMEOUT - 1) tick();
      ma_done = 1'b1; ma_s1 = 13'h1555; ma_s2 = 13'h0AAA;
      tick();
      ma_done = 1'b0;
      n_tests++; if ({res_valid, res_err, res_s1, res_s2} !== {2'b10, 13'h1555, 13'h0AAA}) begin
         n_fail++; $display("FAIL tmo_done_last got=%h exp=%h", {res_valid, res_err, res_s1, res_s2}, {2'b10, 13'h1555, 13'h0AAA}); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      automatic logic [RADIX-1:0] exp_new = REMASK_ON ? 13'h0015 : 13'h0011;
      issue_cmd(13'h0010, 13'h0020, 13'h0030, 13'h0040, 13'h0050, 13'h0060, {13'h0000, 13'h0000});
      tick();
      tick();
      ma_done = 1'b1; ma_s1 = 13'h0BAD; ma_s2 = 13'h0CAB;
      tick();
      ma_done = 1'b0;
      // pending command held during backpressure
      cmd_p1 = 13'h0011; cmd_p2 = 13'h0022; cmd_h1 = 13'h0033; cmd_h2 = 13'h0044;
      rnd = {13'h0000, 13'h0004};
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_tests++; if ({res_valid, cmd_ready, res_err, res_s1, res_s2} !== {3'b100, 13'h0BAD, 13'h0CAB}) begin
            n_fail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {res_valid, cmd_ready, res_err, res_s1, res_s2}, {3'b100, 13'h0BAD, 13'h0CAB}); end
         tick();
      end
      n_tests++; if (ma_p1 !== 13'h0010) begin n_fail++; $display("FAIL bp_no_accept got=%h exp=0010", ma_p1); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_tests++; if ({cmd_ready, busy, res_valid} !== 3'b100) begin
         n_fail++; $display("FAIL bp_idle_after_hs got=%b exp=100", {cmd_ready, busy, res_valid}); end
      tick();
      cmd_valid = 1'b0;
      n_tests++; if ({cmd_ready, busy, rnd_req} !== {2'b01, REMASK_ON}) begin
         n_fail++; $display("FAIL bp_accepted got=%b exp=%b", {cmd_ready, busy, rnd_req}, {2'b01, REMASK_ON}); end
      tick();
      n_tests++; if ({ma_start, ma_p1} !== {1'b1, exp_new}) begin
         n_fail++; $display("FAIL bp_new_launch got=%h exp=%h", {ma_start, ma_p1}, {1'b1, exp_new}); end
      tick();
      finish_run(13'h0001, 13'h0002);
   endtask

   task automatic test_reset_midrun;
      issue_cmd(13'h0AAA, 13'h0555, 13'h0123, 13'h0321, 13'h0111, 13'h0222, {13'h0003, 13'h0007});
      tick();
      repeat (6) tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if ({cmd_ready, rnd_req, ma_start, res_valid, res_err, busy, trig} !== 7'b1000000) begin
         n_fail++; $display("FAIL rst_mid_ctl got=%b exp=1000000", {cmd_ready, rnd_req, ma_start, res_valid, res_err, busy, trig}); end
      n_tests++; if ({ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv, res_s1, res_s2} !== '0) begin
         n_fail++; $display("FAIL rst_mid_data got=%h exp=0", {ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv, res_s1, res_s2}); end
      @(negedge clock);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++; if ({res_valid, busy, cmd_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rst_mid_after[%0d] got=%b exp=001", i, {res_valid, busy, cmd_ready}); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_wrap();
      test_timeout();
      test_back_to_back();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/masked_arith_seq.md
Name: masked_arith_seq

Overview:
- Sequencer in front of the masked_arith datapath for side-channel acquisition runs on the SAKURA-G target.
- Accepts one command holding key shares, message shares, R and kInv, and re-masks the arithmetic shares with fresh PRNG words.
- Pulses the datapath start, waits for done under a timeout, captures s1/s2 and returns them through a valid/ready result port.
- Drives a scope trigger covering exactly the datapath execution window.

Parameters:
RADIX, 13, width of every share/operand; masking is additive mod 2^RADIX
TIMEOUT, 4096, max cycles in WAIT before the run is aborted with error
TW, 16, width of the timeout counter (2^TW > TIMEOUT)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_p1, cmd_p2, cmd_h1, cmd_h2, cmd_r, cmd_kinv  in  RADIX each  operands
rnd  in  2*RADIX  PRNG word; [RADIX-1:0]=r_p, [2*RADIX-1:RADIX]=r_h
rnd_req  out  1  one-cycle pulse: PRNG word consumed
ma_p1, ma_p2, ma_h1, ma_h2, ma_r, ma_kinv  out  RADIX each  registered datapath operands
ma_start  out  1  one-cycle datapath start pulse
ma_done  in  1  datapath done
ma_s1, ma_s2  in  RADIX each  signature shares
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_s1, res_s2  out  RADIX each  captured shares
res_err  out  1  1 = timeout abort (s1/s2 = 0)
busy  out  1  state != IDLE
trig  out  1  1 from ma_start cycle until cycle after done/timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, except cmd_ready=1. Reset mid-run aborts immediately; no result is produced.
- States: IDLE, REMASK, LAUNCH, WAIT, RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch operands, go to REMASK.
- REMASK (1 cycle):
  - ma_p1=p1+r_p, ma_p2=p2-r_p, ma_h1=h1+r_h, ma_h2=h2-r_h, all truncated mod 2^RADIX.
  - ma_r and ma_kinv are passed unchanged.
  - rnd_req=1 this cycle.
  - Go to LAUNCH.
- LAUNCH (1 cycle):
  - ma_start=1, trig set, timeout counter cleared.
  - Go to WAIT.
  - Operands are stable from REMASK until the next command.
- WAIT:
  - Counter increments each cycle.
  - ma_done=1: register ma_s1/ma_s2, res_err=0, go to RESULT.
  - Else if counter==TIMEOUT-1: res_s1=res_s2=0, res_err=1, go to RESULT.
  - ma_done and timeout in the same cycle: done wins.
  - ma_done is sampled only in WAIT; done asserted during LAUNCH is ignored.
- RESULT:
  - res_valid=1; trig cleared on entry.
  - res_* held stable until res_ready, then go to IDLE.
  - cmd_ready=0 throughout.
- Latency, cmd accept to ma_start: 2 cycles.
- Latency, ma_done to res_valid: 1 cycle.
- Back-to-back: a new command is accepted in the cycle after the result handshake (IDLE), never earlier.

Optional Feature:
MASKED_SEQ_REMASK_EN
- Defined: REMASK adds/subtracts PRNG words as above; rnd_req pulses.
- Undefined: shares pass through unchanged; rnd_req tied 0; rnd unused. REMASK still takes 1 cycle, so latency is identical.

Decomposition:
- Package masked_seq_pkg: state enum, default RADIX, default TIMEOUT.
- One sub-module, masked_seq_remask: combinational share add/sub mod 2^RADIX, with the macro bypass inside it.
- FSM, timeout counter and capture registers live in masked_arith_seq.

Test Plan:
1. Reset mid-run: rst_n=0 while in WAIT -> all outputs 0 and cmd_ready=1 within the same cycle; no res_valid after release.
2. Nominal run:
   - Stimulus: p1=0x0123, p2=0x0456, h1=0x0A00, h2=0x0011, rnd={0x0020, 0x0010}.
   - Required: ma_p1=0x0133, ma_p2=0x0446, ma_h1=0x0A20, ma_h2=0x1FF1.
   - ma_start exactly 2 cycles after accept.
   - Model done after 40 cycles with s1=0x0ABC, s2=0x1234 -> res_valid 1 cycle later, res_err=0.
3. Wrap-around: p1=0x1FFF, p2=0x0001, r_p=0x0002 -> ma_p1=0x0001, ma_p2=0x1FFF; p1+p2 sum is preserved mod 2^13.
4. Timeout: ma_done never asserted -> res_valid with res_err=1 and res_s1=res_s2=0 after TIMEOUT cycles in WAIT; trig low after abort. With done at the final cycle, the result is success.
5. Backpressure: res_ready held 0 for 10 cycles -> res_* stable, cmd_ready=0, a pending cmd_valid is not accepted; accepted on the cycle after the handshake.
6. Macro off: same stimulus as test 2 -> ma_p1=0x0123, ma_p2=0x0456, rnd_req never 1, ma_start timing unchanged.
